// File: rtl/dram_defs.sv
// dram_defs: shared address map, request op, classifier state and page-policy types
package dram_defs;
  localparam int ADDR_W = 33;
  localparam int COL_LO_LSB = 3;
  localparam int COL_LO_W = 3;
  localparam int BG_LSB = 6;
  localparam int BG_W = 2;
  localparam int BANK_LSB = 8;
  localparam int BANK_W = 2;
  localparam int COL_HI_LSB = 10;
  localparam int COL_HI_W = 8;
  localparam int ROW_LSB = 18;
  localparam int ROW_W = 15;
  localparam int COL_W = COL_HI_W + COL_LO_W;
  typedef enum logic [1:0] {NULL = 2'd0, HIT = 2'd1, MISS = 2'd2, EMPTY = 2'd3} dram_policy_t;
  typedef enum logic [1:0] {OP_READ = 2'd0, OP_WRITE = 2'd1, OP_IFETCH = 2'd2} req_op_t;
  typedef enum logic [1:0] {IDLE = 2'd0, CLASSIFY = 2'd1, ISSUE = 2'd2, WAIT = 2'd3} classifier_state_t;
endpackage

// File: rtl/dram_req_classifier_if.sv
// dram_req_classifier_if: request handshake plus classified command bundle toward dram_cmd
interface dram_req_classifier_if;
  import dram_defs::*;
  logic req_valid;
  logic req_ready;
  logic [ADDR_W-1:0] req_addr;
  req_op_t req_op;
  logic cmd_done;
  logic cmd_en;
  dram_policy_t policy;
  logic different_bg;
  logic different_b;
  logic [BG_W-1:0] cmd_bg;
  logic [BANK_W-1:0] cmd_bank;
  logic [ROW_W-1:0] cmd_row;
  logic [COL_W-1:0] cmd_col;
  req_op_t cmd_op;
  modport master (
    output req_valid, req_addr, req_op, cmd_done,
    input req_ready, cmd_en, policy, different_bg, different_b, cmd_bg, cmd_bank, cmd_row, cmd_col, cmd_op
  );
  modport slave (
    input req_valid, req_addr, req_op, cmd_done,
    output req_ready, cmd_en, policy, different_bg, different_b, cmd_bg, cmd_bank, cmd_row, cmd_col, cmd_op
  );
endinterface

// File: rtl/dram_bank_table.sv
// dram_bank_table: open-row table, combinational read, synchronous write and clear
module dram_bank_table
  import dram_defs::*;
#(
  parameter int ENTRIES = 16,
  localparam int IDX_W = $clog2(ENTRIES)
) (
  input  logic clk,
  input  logic rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic rd_valid,
  output logic [ROW_W-1:0] rd_row,
  input  logic we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [ROW_W-1:0] wr_row
);
  logic [ENTRIES-1:0] valid;
  logic [ROW_W-1:0] row [ENTRIES];
  assign rd_valid = valid[rd_idx];
  assign rd_row = row[rd_idx];
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (we) begin
      valid[wr_idx] <= 1'b1;
      row[wr_idx] <= wr_row;
    end
  end
endmodule

// File: rtl/dram_req_classifier.sv
// dram_req_classifier: decodes a request, classifies it against the open-row table, issues to dram_cmd.
// DRAM_CLOSED_PAGE_EN: every access is EMPTY and the table is never filled (auto-precharge).
module dram_req_classifier
  import dram_defs::*;
#(
  parameter int NUM_BG = 4,
  parameter int NUM_BANK = 4
) (
  input logic clk,
  input logic rst,
  dram_req_classifier_if.slave bus
);
  localparam int ENTRIES = NUM_BG * NUM_BANK;
  localparam int IDX_W = $clog2(ENTRIES);
  classifier_state_t state, state_n;
  logic [IDX_W-1:0] idx;
  logic tbl_valid, tbl_we;
  logic [ROW_W-1:0] tbl_row;
  logic last_valid;
  logic [BG_W-1:0] last_bg;
  logic [BANK_W-1:0] last_bank;
  dram_policy_t pol_n;
  logic dbg_n, db_n;
  logic unused_tbl;
  logic [2:0] unused_byte;
  assign unused_byte = bus.req_addr[2:0];
  assign bus.req_ready = (state == IDLE) && !rst;
  assign bus.cmd_en = state == ISSUE;
  dram_bank_table #(.ENTRIES(ENTRIES)) u_table (
    .clk(clk),
    .rst(rst),
    .rd_idx(idx),
    .rd_valid(tbl_valid),
    .rd_row(tbl_row),
    .we(tbl_we),
    .wr_idx(idx),
    .wr_row(bus.cmd_row)
  );
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = (state == IDLE && bus.req_valid) ? CLASSIFY :
              (state == CLASSIFY) ? ISSUE :
              (state == ISSUE) ? WAIT :
              (state == WAIT && bus.cmd_done) ? IDLE : state;
    idx = IDX_W'(int'(bus.cmd_bg) * NUM_BANK + int'(bus.cmd_bank));
`ifdef DRAM_CLOSED_PAGE_EN
    pol_n = EMPTY;
    tbl_we = 1'b0;
    unused_tbl = tbl_valid ^ (^tbl_row);
`else
    pol_n = !tbl_valid ? EMPTY : (tbl_row == bus.cmd_row) ? HIT : MISS;
    tbl_we = state == ISSUE;
    unused_tbl = 1'b0;
`endif
    dbg_n = last_valid && (bus.cmd_bg != last_bg);
    db_n = last_valid && (bus.cmd_bg == last_bg) && (bus.cmd_bank != last_bank);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.cmd_bg <= '0;
      bus.cmd_bank <= '0;
      bus.cmd_row <= '0;
      bus.cmd_col <= '0;
      bus.cmd_op <= OP_READ;
      bus.policy <= NULL;
      bus.different_bg <= 1'b0;
      bus.different_b <= 1'b0;
      last_valid <= 1'b0;
      last_bg <= '0;
      last_bank <= '0;
    end else begin
      if (state == IDLE && bus.req_valid) begin
        bus.cmd_bg <= bus.req_addr[BG_LSB +: BG_W];
        bus.cmd_bank <= bus.req_addr[BANK_LSB +: BANK_W];
        bus.cmd_row <= bus.req_addr[ROW_LSB +: ROW_W];
        bus.cmd_col <= {bus.req_addr[COL_HI_LSB +: COL_HI_W], bus.req_addr[COL_LO_LSB +: COL_LO_W]};
        bus.cmd_op <= bus.req_op;
      end
      if (state == CLASSIFY) begin
        bus.policy <= pol_n;
        bus.different_bg <= dbg_n;
        bus.different_b <= db_n;
      end
      if (state == ISSUE) begin
        last_valid <= 1'b1;
        last_bg <= bus.cmd_bg;
        last_bank <= bus.cmd_bank;
      end
      if (state == WAIT && bus.cmd_done) bus.policy <= NULL;
    end
  end
endmodule

// File: tb/tb_dram_req_classifier.sv
// tb_dram_req_classifier: randomized and directed checks against a table-level reference model
module tb_dram_req_classifier;
  import dram_defs::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  bit m_valid [16];
  int m_row [16];
  bit m_last_valid;
  int m_last_bg, m_last_bank;
  always #5 clk = ~clk;
  dram_req_classifier_if bus();
  dram_req_classifier #(.NUM_BG(4), .NUM_BANK(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic model_reset();
    foreach (m_valid[i]) m_valid[i] = 1'b0;
    foreach (m_row[i]) m_row[i] = 0;
    m_last_valid = 1'b0;
    m_last_bg = 0;
    m_last_bank = 0;
  endtask
  task automatic do_req(input logic [32:0] addr, input logic [1:0] op, input int done_delay, input bit hold_valid);
    int bg, bank, row, col, idx;
    dram_policy_t ep;
    bit edbg, edb;
    bg = int'((addr / 64) % 4);
    bank = int'((addr / 256) % 4);
    row = int'(addr / (33'd1 << 18));
    col = int'(((addr / 1024) % 256) * 8 + (addr / 8) % 8);
    idx = bg * 4 + bank;
`ifdef DRAM_CLOSED_PAGE_EN
    ep = EMPTY;
`else
    ep = !m_valid[idx] ? EMPTY : (m_row[idx] == row) ? HIT : MISS;
`endif
    edbg = m_last_valid && (bg != m_last_bg);
    edb = m_last_valid && (bg == m_last_bg) && (bank != m_last_bank);
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL ready_idle got=%b exp=1 addr=%h", bus.req_ready, addr); end
    bus.req_valid = 1'b1;
    bus.req_addr = addr;
    bus.req_op = req_op_t'(op);
    step();
    bus.req_valid = hold_valid;
    checks++; if (bus.req_ready !== 1'b0 || bus.cmd_en !== 1'b0) begin failures++; $display("FAIL classify_ctl ready=%b en=%b exp=0/0 addr=%h", bus.req_ready, bus.cmd_en, addr); end
    checks++; if (bus.cmd_bg !== 2'(bg) || bus.cmd_bank !== 2'(bank)) begin failures++; $display("FAIL bg_bank got=%0d/%0d exp=%0d/%0d", bus.cmd_bg, bus.cmd_bank, bg, bank); end
    checks++; if (bus.cmd_row !== 15'(row) || bus.cmd_col !== 11'(col)) begin failures++; $display("FAIL row_col got=%h/%h exp=%h/%h", bus.cmd_row, bus.cmd_col, row, col); end
    checks++; if (bus.cmd_op !== req_op_t'(op)) begin failures++; $display("FAIL cmd_op got=%0d exp=%0d", bus.cmd_op, op); end
    step();
    checks++; if (bus.cmd_en !== 1'b1) begin failures++; $display("FAIL cmd_en_pulse got=%b exp=1 addr=%h", bus.cmd_en, addr); end
    checks++; if (bus.policy !== ep) begin failures++; $display("FAIL policy got=%s exp=%s addr=%h", bus.policy.name(), ep.name(), addr); end
    checks++; if (bus.different_bg !== edbg || bus.different_b !== edb) begin failures++; $display("FAIL flags got=%b%b exp=%b%b addr=%h", bus.different_bg, bus.different_b, edbg, edb, addr); end
    step();
    checks++; if (bus.cmd_en !== 1'b0 || bus.req_ready !== 1'b0 || bus.policy !== ep) begin failures++; $display("FAIL wait_entry en=%b ready=%b pol=%s exp=0/0/%s", bus.cmd_en, bus.req_ready, bus.policy.name(), ep.name()); end
    for (int i = 0; i < done_delay; i++) begin
      step();
      checks++; if (bus.cmd_en !== 1'b0 || bus.req_ready !== 1'b0 || bus.policy !== ep) begin failures++; $display("FAIL wait_hold en=%b ready=%b pol=%s exp=0/0/%s", bus.cmd_en, bus.req_ready, bus.policy.name(), ep.name()); end
    end
    bus.req_valid = 1'b0;
    bus.cmd_done = 1'b1;
    step();
    bus.cmd_done = 1'b0;
    checks++; if (bus.policy !== NULL || bus.req_ready !== 1'b1 || bus.cmd_en !== 1'b0) begin failures++; $display("FAIL done_idle pol=%s ready=%b en=%b exp=NULL/1/0", bus.policy.name(), bus.req_ready, bus.cmd_en); end
`ifndef DRAM_CLOSED_PAGE_EN
    m_valid[idx] = 1'b1;
    m_row[idx] = row;
`endif
    m_last_valid = 1'b1;
    m_last_bg = bg;
    m_last_bank = bank;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL ready_in_reset got=%b exp=0", bus.req_ready); end
    rst = 1'b0;
    #1;
    model_reset();
    checks++; if (bus.req_ready !== 1'b1 || bus.cmd_en !== 1'b0) begin failures++; $display("FAIL reset_ctl ready=%b en=%b exp=1/0", bus.req_ready, bus.cmd_en); end
    checks++; if (bus.policy !== NULL || bus.different_bg !== 1'b0 || bus.different_b !== 1'b0) begin failures++; $display("FAIL reset_class pol=%s flags=%b%b exp=NULL/00", bus.policy.name(), bus.different_bg, bus.different_b); end
    checks++; if (bus.cmd_bg !== 2'd0 || bus.cmd_bank !== 2'd0 || bus.cmd_row !== 15'd0 || bus.cmd_col !== 11'd0 || bus.cmd_op !== OP_READ) begin failures++; $display("FAIL reset_fields bg=%0d bank=%0d row=%h col=%h op=%0d exp=0", bus.cmd_bg, bus.cmd_bank, bus.cmd_row, bus.cmd_col, bus.cmd_op); end
  endtask
  task automatic test_directed();
    do_req(33'h0_0004_0000, 2'd0, 0, 1'b0);
    do_req(33'h0_0004_0000, 2'd1, 1, 1'b0);
    do_req(33'h0_0008_0000, 2'd2, 2, 1'b0);
    do_req(33'h0_0008_0000, 2'd0, 0, 1'b0);
    do_req(33'h0_0004_0040, 2'd1, 1, 1'b0);
    do_req(33'h0_0004_0140, 2'd0, 3, 1'b0);
  endtask
  task automatic test_reset_mid_wait();
    bus.req_valid = 1'b1;
    bus.req_addr = 33'h0_0004_0000;
    bus.req_op = OP_READ;
    step();
    bus.req_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    bus.cmd_done = 1'b1;
    step();
    checks++; if (bus.req_ready !== 1'b0 || bus.cmd_en !== 1'b0 || bus.policy !== NULL) begin failures++; $display("FAIL mid_reset ready=%b en=%b pol=%s exp=0/0/NULL", bus.req_ready, bus.cmd_en, bus.policy.name()); end
    checks++; if (bus.cmd_row !== 15'd0 || bus.cmd_bg !== 2'd0) begin failures++; $display("FAIL mid_reset_fields row=%h bg=%0d exp=0/0", bus.cmd_row, bus.cmd_bg); end
    rst = 1'b0;
    bus.cmd_done = 1'b0;
    #1;
    model_reset();
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL ready_after_reset got=%b exp=1", bus.req_ready); end
    do_req(33'h0_0004_0000, 2'd0, 0, 1'b0);
  endtask
  task automatic test_back_to_back();
    do_req(33'h0_0004_0000, 2'd0, 0, 1'b1);
    do_req(33'h0_0004_0000, 2'd1, 1, 1'b1);
    do_req(33'h0_0004_0000, 2'd2, 2, 1'b1);
  endtask
  task automatic test_random();
    logic [32:0] a;
    for (int n = 0; n < 40; n++) begin
      a = {15'($urandom_range(0, 2)), 8'($urandom), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 3'($urandom), 3'($urandom)};
      do_req(a, 2'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'($urandom));
    end
  endtask
  initial begin
    bus.req_valid = 1'b0;
    bus.req_addr = '0;
    bus.req_op = OP_READ;
    bus.cmd_done = 1'b0;
    model_reset();
    test_reset();
    test_directed();
    test_reset_mid_wait();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
